// File: rtl/uart_tx_bit_sched.sv
// Transmit bit sequencer for the APB UART: walks one latched character frame
// (start, data, optional parity, stop) onto SOUT, one bit per OVERSAMPLE baud enables.
module uart_tx_bit_sched #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clear_i,
    input  logic       baudce_i,
    input  logic       start_i,
    input  logic [7:0] din_i,
    input  logic [1:0] wls_i,
    input  logic       stb_i,
    input  logic       pen_i,
    input  logic       eps_i,
    input  logic       sp_i,
    input  logic       bc_i,
    output logic       sout_o,
    output logic       busy_o,
    output logic       txfinished_o
);
    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam logic [TW-1:0] TERM_BIT  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TERM_1P5  = TW'(3 * OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TERM_2BIT = TW'(2 * OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic            sout_q, sout_d;
    logic            busy_q, busy_d;
    logic            fin_q, fin_d;
    logic [7:0]      din_q, din_d;
    logic [1:0]      wls_q, wls_d;
    logic            stb_q, stb_d;
    logic            pen_q, pen_d;
    logic            eps_q, eps_d;
    logic            sp_q, sp_d;
    logic [TW-1:0]   term;
    logic            bit_end;

    function automatic logic parity_bit(logic [7:0] data, logic [1:0] wls,
                                        logic eps, logic sp);
        logic [7:0] mask;
        logic       x;
        mask = ~(8'hE0 << wls);
        x    = ^(data & mask);
        return sp ? ~eps : (eps ? x : ~x);
    endfunction

    // The whole stop period is counted as one long "bit" so 1.5 and 2 stop bits need no bit counter.
    function automatic logic [TW-1:0] stop_term(logic stb, logic [1:0] wls);
        if (!stb) return TERM_BIT;
        return (wls == 2'b00) ? TERM_1P5 : TERM_2BIT;
    endfunction

    function automatic logic line_level(state_e st, logic [2:0] idx, logic [7:0] data,
                                        logic [1:0] wls, logic eps, logic sp);
        case (st)
            S_START:  return 1'b0;
            S_DATA:   return data[idx];
            S_PARITY: return parity_bit(data, wls, eps, sp);
            default:  return 1'b1;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        fin_d   = 1'b0;
        din_d   = din_q;
        wls_d   = wls_q;
        stb_d   = stb_q;
        pen_d   = pen_q;
        eps_d   = eps_q;
        sp_d    = sp_q;

        term    = (state_q == S_STOP) ? stop_term(stb_q, wls_q) : TERM_BIT;
        bit_end = baudce_i && (tick_q == term);

        if (state_q != S_IDLE && baudce_i) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    din_d   = din_i;
                    wls_d   = wls_i;
                    stb_d   = stb_i;
                    pen_d   = pen_i;
                    eps_d   = eps_i;
                    sp_d    = sp_i;
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == ({1'b0, wls_q} + 3'd4)) begin
                        state_d = pen_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    fin_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Break overrides the line level only; sequencing above is untouched.
        sout_d = bc_i ? 1'b0 : line_level(state_d, bit_d, din_d, wls_d, eps_d, sp_d);

        if (clear_i) begin
            state_d = S_IDLE;
            tick_d  = '0;
            bit_d   = '0;
            fin_d   = 1'b0;
            sout_d  = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            sout_q  <= 1'b1;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
        end
    end

    // Frame configuration is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk_i) begin
        din_q <= din_d;
        wls_q <= wls_d;
        stb_q <= stb_d;
        pen_q <= pen_d;
        eps_q <= eps_d;
        sp_q  <= sp_d;
    end

    assign sout_o       = sout_q;
    assign busy_o       = busy_q;
    assign txfinished_o = fin_q;

endmodule
